mpmc11_rd_gather: RTL and testbench



---
 rtl/mpmc11_pkg.sv | 20 ++
 rtl/mpmc11_rd_line_buf.sv | 34 +++
 rtl/mpmc11_rd_gather.sv | 135 +++++++++++++
 tb/tb_mpmc11_rd_gather.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared mpmc11 controller types and constants: read-gather FSM state,
// default strip geometry (shared with the write path) and index-width helper.
package mpmc11_pkg;

   function automatic int mpmc11_sidx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MPMC11_STRIP_W    = 128;
   localparam int MPMC11_MAX_STRIPS = 4;
   localparam int MPMC11_CNT_W      = 6;
   localparam int MPMC11_SIDX_W     = mpmc11_sidx_w(MPMC11_MAX_STRIPS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      HOLD   = 2'd2
   } mpmc11_rd_gather_state_t;

endpackage

// File: rtl/mpmc11_rd_line_buf.sv
// Line buffer for the read-gather path: MAX_STRIPS slots of STRIP_W bits,
// one slot written per enabled cycle, whole line presented flat.
module mpmc11_rd_line_buf
   import mpmc11_pkg::*;
#(
   parameter int STRIP_W    = MPMC11_STRIP_W,
   parameter int MAX_STRIPS = MPMC11_MAX_STRIPS,
   parameter int SIDX_W     = mpmc11_sidx_w(MAX_STRIPS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [SIDX_W-1:0]             idx,
   input  logic [STRIP_W-1:0]            wdata,
   output logic [STRIP_W*MAX_STRIPS-1:0] line
);

   logic [MAX_STRIPS-1:0][STRIP_W-1:0] slot;

   genvar g;
   generate
      for (g = 0; g < MAX_STRIPS; g++) begin : g_slot
         logic [STRIP_W-1:0] q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                             q <= '0;
            else if (we && idx == SIDX_W'(g))    q <= wdata;
         end
         assign slot[g] = q;
      end
   endgenerate

   assign line = slot;

endmodule

// File: rtl/mpmc11_rd_gather.sv
// Read-return gather: counts returning strips, assembles them into a line and
// hands it off with valid/ack. Optional beat timeout: MPMC11_RD_GATHER_TIMEOUT_EN.
module mpmc11_rd_gather
   import mpmc11_pkg::*;
#(
   parameter int STRIP_W    = MPMC11_STRIP_W,
   parameter int MAX_STRIPS = MPMC11_MAX_STRIPS,
   parameter int TMO_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [5:0]                    num_strips,
   input  logic                          rd_valid,
   input  logic [STRIP_W-1:0]            rd_data,
   output logic [5:0]                    rd_strip_cnt,
   output logic                          busy,
   output logic                          line_valid,
   output logic [STRIP_W*MAX_STRIPS-1:0] line,
   input  logic                          line_ack,
   output logic                          err,
`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
   output logic                          tmo,
`endif
   input  logic                          err_clr
);

   localparam int         SIDX_W = mpmc11_sidx_w(MAX_STRIPS);
   localparam logic [6:0] MAX_S  = 7'(MAX_STRIPS);

   mpmc11_rd_gather_state_t state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [5:0] nstr_q, nstr_d;
   logic       err_q;
   logic       err_evt;
   logic       we;
   logic       tmo_hit;

`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q;
   logic          tmo_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nstr_d  = nstr_q;
      err_evt = 1'b0;
      we      = 1'b0;
      tmo_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_valid) err_evt = 1'b1;
            if (start) begin
               nstr_d  = num_strips;
               cnt_d   = '0;
               state_d = GATHER;
            end
         end
         GATHER: begin
            if (start) err_evt = 1'b1;
            if (rd_valid) begin
               // Beats past the buffer are counted but never wrap into low slots.
               if ({1'b0, cnt_q} < MAX_S) we = 1'b1;
               else                       err_evt = 1'b1;
               if (cnt_q != 6'd63)        cnt_d = cnt_q + 6'd1;
               if (cnt_q == nstr_q)       state_d = HOLD;
            end
`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TMO_CYCLES - 1)) begin
               tmo_hit = 1'b1;
               err_evt = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         HOLD: begin
            if (start || rd_valid) err_evt = 1'b1;
            if (line_ack)          state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         nstr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nstr_q  <= nstr_d;
         if (err_evt)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_q <= tmo_hit;
         if ((state_q == IDLE && start) || rd_valid || tmo_hit) tmo_cnt_q <= '0;
         else if (state_q == GATHER)                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
   assign tmo = tmo_q;
`else
   wire unused_tmo = (TMO_CYCLES != 0) | tmo_hit;
`endif

   mpmc11_rd_line_buf #(
      .STRIP_W    (STRIP_W),
      .MAX_STRIPS (MAX_STRIPS),
      .SIDX_W     (SIDX_W)
   ) u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .idx   (cnt_q[SIDX_W-1:0]),
      .wdata (rd_data),
      .line  (line)
   );

   assign rd_strip_cnt = cnt_q;
   assign busy         = (state_q == GATHER);
   assign line_valid   = (state_q == HOLD);
   assign err          = err_q;

endmodule

// File: tb/tb_mpmc11_rd_gather.sv
// Randomized scoreboard bench for mpmc11_rd_gather; covers the timeout
// feature when MPMC11_RD_GATHER_TIMEOUT_EN is defined.
module tb_mpmc11_rd_gather;

   localparam int SW = 128;
   localparam int MS = 4;
   localparam int LW = SW * MS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [5:0]    num_strips = '0;
   logic          rd_valid = 1'b0;
   logic [SW-1:0] rd_data = '0;
   logic [5:0]    rd_strip_cnt;
   logic          busy;
   logic          line_valid;
   logic [LW-1:0] line;
   logic          line_ack = 1'b0;
   logic          err;
   logic          err_clr = 1'b0;
`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
   logic          tmo;
`endif

   mpmc11_rd_gather #(.STRIP_W(SW), .MAX_STRIPS(MS), .TMO_CYCLES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_strips   (num_strips),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_strip_cnt (rd_strip_cnt),
      .busy         (busy),
      .line_valid   (line_valid),
      .line         (line),
      .line_ack     (line_ack),
      .err          (err),
`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
      .tmo          (tmo),
`endif
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LW-1:0] line;
      int            cnt;
      bit            err;
   } exp_t;

   exp_t          q[$];
   logic [SW-1:0] mdl[MS];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LW-1:0] model_line();
      logic [LW-1:0] r;
      for (int k = 0; k < MS; k++) r[k*SW +: SW] = mdl[k];
      return r;
   endfunction

   function automatic logic [SW-1:0] rnd_strip();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // poke: 0 none, 1 rd_valid during HOLD, 2 start coincident with ack
   task automatic burst(input int n, input int maxgap, input int ackdly, input int poke);
      exp_t          e;
      logic [SW-1:0] d;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      start = 1'b1; num_strips = 6'(n); tick(); start = 1'b0;
      chk("busy_start", busy, 1);
      chk("cnt_start", rd_strip_cnt, 0);
      for (int i = 0; i <= n; i++) begin
         int g;
         g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
         repeat (g) tick();
         d = rnd_strip();
         if (i < MS) mdl[i] = d;
         if (i == n) begin
            e.line = model_line();
            e.cnt  = (n + 1 > 63) ? 63 : n + 1;
            e.err  = (n >= MS);
            q.push_back(e);
         end
         rd_valid = 1'b1; rd_data = d; tick(); rd_valid = 1'b0;
         chk("cnt_step", rd_strip_cnt, (i + 1 > 63) ? 63 : i + 1);
      end
      chk("lv_latency", line_valid, 1);
      chk("busy_done", busy, 0);
      if (poke == 1) begin
         rd_valid = 1'b1; rd_data = rnd_strip(); tick(); rd_valid = 1'b0;
         chk("err_hold_rd", err, 1);
         chk("lv_hold_rd", line_valid, 1);
      end
      repeat (ackdly) tick();
      line_ack = 1'b1;
      if (poke == 2) start = 1'b1;
      tick();
      line_ack = 1'b0; start = 1'b0;
      chk("lv_after_ack", line_valid, 0);
      chk("busy_after_ack", busy, 0);
      if (poke == 2) chk("err_start_ack", err, 1);
   endtask

   // Scoreboard monitor: pops on each new line presentation, checks stability while held.
   logic          lv_prev = 1'b0;
   logic [LW-1:0] held;
   always @(negedge clk) begin
      exp_t e;
      if (rst) lv_prev = 1'b0;
      else begin
         if (line_valid && !lv_prev) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_line actual=line_valid expected=no_line");
            end else begin
               e = q.pop_front();
               chk("line", line, e.line);
               chk("line_cnt", rd_strip_cnt, e.cnt);
               chk("line_err", err, e.err);
            end
            held = line;
         end else if (line_valid) chk("line_stable", line, held);
         lv_prev = line_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < MS; k++) mdl[k] = '0;
      repeat (3) tick();
      chk("rst_cnt", rd_strip_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lv", line_valid, 0);
      chk("rst_line", line, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      tick();

      burst(3, 0, 0, 0);
      burst(3, 2, 2, 0);
      burst(0, 0, 1, 0);
      burst(5, 0, 0, 0);

      rd_valid = 1'b1; tick(); rd_valid = 1'b0;
      chk("err_idle_rd", err, 1);
      err_clr = 1'b1; rd_valid = 1'b1; tick(); rd_valid = 1'b0;
      chk("err_set_wins", err, 1);
      tick(); err_clr = 1'b0;
      chk("err_clr", err, 0);

      burst(2, 1, 1, 1);
      burst(1, 0, 0, 2);

      // Reset in the middle of a burst, with err already set.
      start = 1'b1; num_strips = 6'd3; tick(); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_valid = 1'b1; rd_data = rnd_strip(); tick(); rd_valid = 1'b0;
      end
      start = 1'b1; tick(); start = 1'b0;
      chk("err_start_gather", err, 1);
      rst = 1'b1; #1;
      chk("mid_rst_cnt", rd_strip_cnt, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_lv", line_valid, 0);
      chk("mid_rst_line", line, 0);
      chk("mid_rst_err", err, 0);
      for (int k = 0; k < MS; k++) mdl[k] = '0;
      tick(); rst = 1'b0; tick();
      burst(1, 0, 0, 0);

      burst(63, 0, 0, 0);

      for (int r = 0; r < 30; r++)
         burst($urandom_range(7, 0), $urandom_range(2, 0), $urandom_range(3, 0),
               $urandom_range(2, 0));

`ifdef MPMC11_RD_GATHER_TIMEOUT_EN
      begin
         int            found;
         logic [SW-1:0] d;
         found = 0;
         err_clr = 1'b1; tick(); err_clr = 1'b0;
         start = 1'b1; num_strips = 6'd3; tick(); start = 1'b0;
         d = rnd_strip(); mdl[0] = d;
         rd_valid = 1'b1; rd_data = d; tick(); rd_valid = 1'b0;
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (tmo) begin
               found = k;
               break;
            end
         end
         chk("tmo_delay", found, 8);
         chk("tmo_err", err, 1);
         chk("tmo_busy", busy, 0);
         chk("tmo_lv", line_valid, 0);
         tick();
         chk("tmo_pulse", tmo, 0);
      end
`endif

      repeat (3) tick();
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
